// File: rtl/kc_ls1u_plus_cpu_if.sv
// rtl/kc_ls1u_plus_cpu_if.sv - instruction and data memory bus of the kc_ls1u_plus CPU core
interface kc_ls1u_plus_cpu_if;
  logic [23:0] iaddr;
  logic [15:0] instr;
  logic [23:0] daddr;
  logic        dwrite;
  logic [7:0]  ddata_i;
  logic [7:0]  ddata_o;

  modport master (
    output iaddr,
    input  instr,
    output daddr,
    output dwrite,
    input  ddata_i,
    output ddata_o
  );

  modport slave (
    input  iaddr,
    output instr,
    input  daddr,
    input  dwrite,
    output ddata_i,
    input  ddata_o
  );
endinterface

// File: rtl/kc_ls1u_plus_cpu.sv
// rtl/kc_ls1u_plus_cpu.sv - 8-bit single-cycle Harvard CPU core with vectored interrupt and WAIT stall
module kc_ls1u_plus_cpu #(
  parameter logic [23:0] RST_PC = 24'h000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   INT,
  input  logic                   WAIT,
  input  logic [23:0]            IVEC_addr,
  kc_ls1u_plus_cpu_if.master     bus
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ALU  = 4'h3,
    OP_ADDI = 4'h4,
    OP_LD   = 4'h5,
    OP_ST   = 4'h6,
    OP_BR   = 4'h7,
    OP_JR   = 4'h8,
    OP_EI   = 4'h9,
    OP_DI   = 4'hA,
    OP_IRET = 4'hB
  } opcode_e;

  // Architectural state
  logic [7:0]  rf [16];
  logic        z;
  logic        c;
  logic [23:0] pc;
  logic [23:0] epc;
  logic        ie;

  // Instruction fields
  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  fn;
  logic [7:0]  imm;
  logic [7:0]  a;
  logic [7:0]  b;

  // Next-state values produced by the decoder
  logic        rf_we;
  logic [7:0]  rf_wd;
  logic        fl_we;
  logic        z_n;
  logic        c_n;
  logic [23:0] pc_n;
  logic        ie_n;
  logic        irq_take;
  logic        br_taken;
  logic [8:0]  wide;

  assign op  = bus.instr[15:12];
  assign rd  = bus.instr[11:8];
  assign fn  = bus.instr[7:4];
  assign rs  = bus.instr[3:0];
  assign imm = bus.instr[7:0];
  assign a   = rf[rd];
  assign b   = rf[rs];

  // An interrupt only wins at a posedge that is neither in reset nor stalled
  assign irq_take = INT & ie;

  assign bus.iaddr   = pc;
  assign bus.daddr   = {rf[15], rf[14], rf[13]};
  assign bus.ddata_o = rf[rd];
  assign bus.dwrite  = (op == OP_ST) & rst & ~WAIT & ~irq_take;

  // Decode the current instruction into register, flag, PC and IE updates
  always_comb begin
    rf_we    = 1'b0;
    rf_wd    = 8'h00;
    fl_we    = 1'b0;
    z_n      = z;
    c_n      = c;
    pc_n     = pc + 24'd1;
    ie_n     = ie;
    br_taken = 1'b0;
    wide     = 9'h000;
    case (op)
      OP_LDI: begin
        rf_we = 1'b1;
        rf_wd = imm;
      end
      OP_MOV: begin
        rf_we = 1'b1;
        rf_wd = b;
      end
      OP_ALU: begin
        if (fn[3] == 1'b0) begin
          rf_we = 1'b1;
          fl_we = 1'b1;
          case (fn[2:0])
            3'd0: wide = {1'b0, a} + {1'b0, b};
            3'd1: wide = {1'b0, a} - {1'b0, b};
            3'd2: wide = {1'b0, a & b};
            3'd3: wide = {1'b0, a | b};
            3'd4: wide = {1'b0, a ^ b};
            3'd5: wide = {1'b0, ~b};
            3'd6: wide = {b[7], b[6:0], 1'b0};
            default: wide = {b[0], 1'b0, b[7:1]};
          endcase
          rf_wd = wide[7:0];
          z_n   = (wide[7:0] == 8'h00);
          c_n   = wide[8];
        end
      end
      OP_ADDI: begin
        wide  = {1'b0, a} + {1'b0, imm};
        rf_we = 1'b1;
        rf_wd = wide[7:0];
        fl_we = 1'b1;
        z_n   = (wide[7:0] == 8'h00);
        c_n   = wide[8];
      end
      OP_LD: begin
        rf_we = 1'b1;
        rf_wd = bus.ddata_i;
      end
      OP_BR: begin
        case (rd)
          4'd0:    br_taken = 1'b1;
          4'd1:    br_taken = z;
          4'd2:    br_taken = ~z;
          4'd3:    br_taken = c;
          4'd4:    br_taken = ~c;
          default: br_taken = 1'b0;
        endcase
        if (br_taken) begin
          pc_n = pc + 24'd1 + {{16{imm[7]}}, imm};
        end
      end
      OP_JR: begin
        pc_n = {rf[15], rf[14], rf[13]};
      end
      OP_EI: begin
        ie_n = 1'b1;
      end
      OP_DI: begin
        ie_n = 1'b0;
      end
      OP_IRET: begin
        pc_n = epc;
        ie_n = 1'b1;
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

  // Retire one instruction per non-stalled edge; reset beats WAIT beats interrupt
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf  <= '{default: 8'h00};
      z   <= 1'b0;
      c   <= 1'b0;
      pc  <= RST_PC;
      epc <= 24'h000000;
      ie  <= 1'b0;
    end else if (!WAIT) begin
      if (irq_take) begin
        epc <= pc;
        ie  <= 1'b0;
        pc  <= IVEC_addr;
      end else begin
        pc <= pc_n;
        ie <= ie_n;
        if (rf_we) begin
          rf[rd] <= rf_wd;
        end
        if (fl_we) begin
          z <= z_n;
          c <= c_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_kc_ls1u_plus_cpu.sv
// tb/tb_kc_ls1u_plus_cpu.sv - table-driven self-checking bench for kc_ls1u_plus_cpu
module tb_kc_ls1u_plus_cpu;

  logic        clk;
  logic        rst;
  logic        int_req;
  logic        wait_req;
  logic [23:0] ivec;
  logic [7:0]  ram [256];

  int checks;
  int errors;

  kc_ls1u_plus_cpu_if bus ();

  kc_ls1u_plus_cpu #(.RST_PC(24'h000000)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (int_req),
    .WAIT      (wait_req),
    .IVEC_addr (ivec),
    .bus       (bus.master)
  );

  typedef struct {
    logic [15:0] instr;
    logic        wt;
    logic        irq;
    logic [23:0] e_iaddr;
    logic        e_dw;
    logic        dchk;
    logic [23:0] e_daddr;
    logic [7:0]  e_ddo;
  } step_t;

  step_t steps[$];
  step_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data RAM model: combinational read, posedge write
  assign bus.ddata_i = ram[bus.daddr[7:0]];
  always @(posedge clk) begin
    if (bus.dwrite) ram[bus.daddr[7:0]] <= bus.ddata_o;
  end

  task automatic add(input logic [15:0] instr, input logic wt, input logic irq,
                     input logic [23:0] ia, input logic dw, input logic dchk,
                     input logic [23:0] da, input logic [7:0] ddo);
    step_t s;
    s.instr = instr; s.wt = wt; s.irq = irq; s.e_iaddr = ia; s.e_dw = dw;
    s.dchk = dchk; s.e_daddr = da; s.e_ddo = ddo;
    steps.push_back(s);
  endtask

  task automatic chk(input string name, input int idx, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d actual %h required %h", name, idx, act, req);
    end
  endtask

  initial begin
    step_t e;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ivec     = 24'hFF0000;
    int_req  = 1'b0;
    wait_req = 1'b0;
    rst      = 1'b0;
    bus.instr = 16'h0000;

    //    instr    WAIT INT iaddr       dw dchk daddr       ddata_o
    add(16'h0000, 0, 0, 24'h000000, 0, 0, 24'h000000, 8'h00);
    add(16'h0000, 0, 0, 24'h000001, 0, 0, 24'h000000, 8'h00);
    add(16'h11F0, 0, 0, 24'h000002, 0, 0, 24'h000000, 8'h00);
    add(16'h1220, 0, 0, 24'h000003, 0, 0, 24'h000000, 8'h00);
    add(16'h3102, 0, 0, 24'h000004, 0, 0, 24'h000000, 8'h00);
    add(16'h7302, 0, 0, 24'h000005, 0, 0, 24'h000000, 8'h00);
    add(16'h6100, 0, 0, 24'h000008, 1, 1, 24'h000000, 8'h10);
    add(16'h3111, 0, 0, 24'h000009, 0, 0, 24'h000000, 8'h00);
    add(16'h7103, 0, 0, 24'h00000A, 0, 0, 24'h000000, 8'h00);
    add(16'h74FE, 0, 0, 24'h00000E, 0, 0, 24'h000000, 8'h00);
    add(16'h72FE, 0, 0, 24'h00000D, 0, 0, 24'h000000, 8'h00);
    add(16'h115A, 0, 0, 24'h00000E, 0, 0, 24'h000000, 8'h00);
    add(16'h1D05, 0, 0, 24'h00000F, 0, 0, 24'h000000, 8'h00);
    add(16'h6100, 0, 0, 24'h000010, 1, 1, 24'h000005, 8'h5A);
    add(16'h5300, 0, 0, 24'h000011, 0, 1, 24'h000005, 8'h00);
    add(16'h6300, 0, 0, 24'h000012, 1, 1, 24'h000005, 8'h5A);
    add(16'h44FF, 0, 0, 24'h000013, 0, 0, 24'h000000, 8'h00);
    add(16'h4401, 0, 0, 24'h000014, 0, 0, 24'h000000, 8'h00);
    add(16'h7110, 0, 0, 24'h000015, 0, 0, 24'h000000, 8'h00);
    add(16'h6400, 0, 0, 24'h000026, 1, 1, 24'h000005, 8'h00);
    add(16'h6100, 1, 0, 24'h000027, 0, 1, 24'h000005, 8'h5A);
    add(16'h6100, 1, 0, 24'h000027, 0, 1, 24'h000005, 8'h5A);
    add(16'h6100, 1, 0, 24'h000027, 0, 1, 24'h000005, 8'h5A);
    add(16'h6100, 0, 0, 24'h000027, 1, 1, 24'h000005, 8'h5A);
    add(16'h3561, 0, 0, 24'h000028, 0, 0, 24'h000000, 8'h00);
    add(16'h3671, 0, 0, 24'h000029, 0, 0, 24'h000000, 8'h00);
    add(16'h3751, 0, 0, 24'h00002A, 0, 0, 24'h000000, 8'h00);
    add(16'h3865, 0, 0, 24'h00002B, 0, 0, 24'h000000, 8'h00);
    add(16'h7301, 0, 0, 24'h00002C, 0, 0, 24'h000000, 8'h00);
    add(16'h6500, 0, 0, 24'h00002E, 1, 1, 24'h000005, 8'hB4);
    add(16'h6600, 0, 0, 24'h00002F, 1, 1, 24'h000005, 8'h2D);
    add(16'h6700, 0, 0, 24'h000030, 1, 1, 24'h000005, 8'hA5);
    add(16'h6800, 0, 0, 24'h000031, 1, 1, 24'h000005, 8'h68);
    add(16'h3881, 0, 0, 24'h000032, 0, 0, 24'h000000, 8'h00);
    add(16'h6800, 0, 0, 24'h000033, 1, 1, 24'h000005, 8'h68);
    add(16'h9000, 0, 0, 24'h000034, 0, 0, 24'h000000, 8'h00);
    add(16'h0000, 1, 1, 24'h000035, 0, 0, 24'h000000, 8'h00);
    add(16'h6100, 0, 1, 24'h000035, 0, 0, 24'h000000, 8'h00);
    add(16'h0000, 0, 1, 24'hFF0000, 0, 0, 24'h000000, 8'h00);
    add(16'hB000, 0, 1, 24'hFF0001, 0, 0, 24'h000000, 8'h00);
    add(16'h6100, 0, 1, 24'h000035, 0, 0, 24'h000000, 8'h00);
    add(16'hB000, 0, 0, 24'hFF0000, 0, 0, 24'h000000, 8'h00);
    add(16'h6100, 0, 0, 24'h000035, 1, 1, 24'h000005, 8'h5A);
    add(16'hA000, 0, 0, 24'h000036, 0, 0, 24'h000000, 8'h00);
    add(16'h0000, 0, 1, 24'h000037, 0, 0, 24'h000000, 8'h00);
    add(16'h0000, 0, 0, 24'h000038, 0, 0, 24'h000000, 8'h00);
    add(16'h1D40, 0, 0, 24'h000039, 0, 0, 24'h000000, 8'h00);
    add(16'h8000, 0, 0, 24'h00003A, 0, 1, 24'h000040, 8'h00);
    add(16'h1DFF, 0, 0, 24'h000040, 0, 0, 24'h000000, 8'h00);
    add(16'h1EFF, 0, 0, 24'h000041, 0, 0, 24'h000000, 8'h00);
    add(16'h1FFF, 0, 0, 24'h000042, 0, 0, 24'h000000, 8'h00);
    add(16'h8000, 0, 0, 24'h000043, 0, 1, 24'hFFFFFF, 8'h00);
    add(16'h0000, 0, 0, 24'hFFFFFF, 0, 0, 24'h000000, 8'h00);
    add(16'h0000, 0, 0, 24'h000000, 0, 0, 24'h000000, 8'h00);

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_iaddr",   -1, bus.iaddr, 24'h000000);
    chk("reset_dwrite",  -1, {23'h0, bus.dwrite}, 24'h000000);
    chk("reset_daddr",   -1, bus.daddr, 24'h000000);
    chk("reset_ddata_o", -1, {16'h0, bus.ddata_o}, 24'h000000);
    rst = 1'b1;

    foreach (steps[i]) begin
      bus.instr = steps[i].instr;
      wait_req  = steps[i].wt;
      int_req   = steps[i].irq;
      exp_q.push_back(steps[i]);
      #1;
      e = exp_q.pop_front();
      chk("iaddr",  i, bus.iaddr, e.e_iaddr);
      chk("dwrite", i, {23'h0, bus.dwrite}, {23'h0, e.e_dw});
      if (e.dchk) begin
        chk("daddr",   i, bus.daddr, e.e_daddr);
        chk("ddata_o", i, {16'h0, bus.ddata_o}, {16'h0, e.e_ddo});
      end
      @(negedge clk);
    end

    // Reset asserted during a stall with an instruction that would store
    bus.instr = 16'h6100;
    wait_req  = 1'b1;
    int_req   = 1'b1;
    rst       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("stall_reset_iaddr",  -2, bus.iaddr, 24'h000000);
    chk("stall_reset_daddr",  -2, bus.daddr, 24'h000000);
    chk("stall_reset_dwrite", -2, {23'h0, bus.dwrite}, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
